// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: elastic pipeline register with one-entry skid buffer, flush and freeze; PIPE_STAGE_STATS_EN adds saturating stall/freeze/flush counters
module pipe_stage_skid_reg #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_STATS_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  freeze_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
`endif
  output logic [DATA_W-1:0] out_data
);
  logic              main_v, skid_v, main_v_n, skid_v_n, accept, drain;
  logic [DATA_W-1:0] main_d, skid_d, main_d_n, skid_d_n;
  assign in_ready  = ~skid_v & ~freeze & ~flush;
  assign out_valid = main_v & ~freeze;
  assign out_data  = main_d;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;
  // freeze needs no explicit branch: it already forces accept and drain low
  always_comb begin
    main_v_n = flush ? 1'b0 : main_v ? (skid_v | ~drain | accept) : accept;
    skid_v_n = flush ? 1'b0 : skid_v ? ~drain : (main_v & accept & ~drain);
    main_d_n = flush ? RESET_VAL
             : (main_v & skid_v & drain) ? skid_d
             : (accept & (~main_v | drain)) ? in_data : main_d;
    skid_d_n = flush ? RESET_VAL
             : (main_v & ~skid_v & accept & ~drain) ? in_data : skid_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
    end else begin
      main_v <= main_v_n;
      skid_v <= skid_v_n;
      main_d <= main_d_n;
      skid_d <= skid_d_n;
    end
`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt  <= '0;
      freeze_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (freeze & ~flush & ~&freeze_cnt) freeze_cnt <= freeze_cnt + 1'b1;
      if (flush & ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed self-checking bench for pipe_stage_skid_reg (stats checks when PIPE_STAGE_STATS_EN is defined)
module tb_pipe_stage_skid_reg;
  localparam int CNT_W = 3;
  logic clk = 0, rst = 1, flush = 0, freeze = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] in_data = 0, out_data;
  int checks = 0, passed = 0;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt, freeze_cnt, flush_cnt;
`endif
  always #5 clk = ~clk;
  pipe_stage_skid_reg #(.DATA_W(32), .RESET_VAL(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt), .flush_cnt(flush_cnt),
`endif
    .out_data(out_data)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic fill_ab;
    out_ready = 0; in_valid = 1; in_data = 32'hA;
    tick;
    in_data = 32'hB;
    tick;
    in_valid = 0;
    #1;
  endtask
  initial begin
    tick; tick;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;
    // streaming at full rate
    in_valid = 1; out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_data = i;
      tick;
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 0;
    tick;
    chk("stream_end_valid", out_valid, 0);
    // skid under backpressure
    out_ready = 0; in_valid = 1; in_data = 32'hA;
    tick;
    chk("skid_a_valid", out_valid, 1);
    chk("skid_one_in_ready", in_ready, 1);
    in_data = 32'hB;
    tick;
    chk("skid_full_in_ready", in_ready, 0);
    chk("skid_full_data", out_data, 32'hA);
    in_valid = 0; out_ready = 1;
    #1;
    chk("skid_drain_a", out_data, 32'hA);
    tick;
    chk("skid_drain_b", out_data, 32'hB);
    chk("skid_drain_b_valid", out_valid, 1);
    chk("skid_drain_in_ready", in_ready, 1);
    tick;
    chk("skid_empty_valid", out_valid, 0);
    // async reset while full
    fill_ab;
    chk("full_before_rst", in_ready, 0);
    rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    rst = 0; in_valid = 1; in_data = 32'h5; out_ready = 1;
    #1;
    chk("post_rst_no_valid", out_valid, 0);
    tick;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 32'h5);
    in_valid = 0;
    tick;
    // flush with freeze while full
    fill_ab;
    flush = 1; freeze = 1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_frz_valid", out_valid, 0);
    tick;
    flush = 0; freeze = 0;
    #1;
    chk("flushed_valid", out_valid, 0);
    chk("flushed_in_ready", in_ready, 1);
    chk("flushed_data", out_data, 0);
    out_ready = 1;
    tick;
    chk("flushed_no_b", out_valid, 0);
    // freeze holding ONE
    out_ready = 0; in_valid = 1; in_data = 32'hC;
    tick;
    freeze = 1; in_data = 32'hD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_in_ready", in_ready, 0);
      chk("frz_out_valid", out_valid, 0);
      chk("frz_data", out_data, 32'hC);
      tick;
    end
    freeze = 0; out_ready = 1;
    #1;
    chk("unfrz_valid", out_valid, 1);
    chk("unfrz_data", out_data, 32'hC);
    chk("unfrz_in_ready", in_ready, 1);
    tick;
    chk("unfrz_next_data", out_data, 32'hD);
    in_valid = 0;
    tick;
    chk("unfrz_empty", out_valid, 0);
`ifdef PIPE_STAGE_STATS_EN
    rst = 1; #1; rst = 0;
    chk("cnt_rst_stall", stall_cnt, 0);
    chk("cnt_rst_flush", flush_cnt, 0);
    in_valid = 1; out_ready = 1; in_data = 32'hE;
    tick;
    in_valid = 0; out_ready = 0;
    for (int i = 0; i < 5; i++) tick;
    chk("stall_5", stall_cnt, 5);
    for (int i = 0; i < 5; i++) tick;
    chk("stall_sat", stall_cnt, 7);
    flush = 1;
    tick; tick;
    flush = 0;
    #1;
    chk("flush_2", flush_cnt, 2);
    chk("freeze_0", freeze_cnt, 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
